// File: rtl/spi_pkg.sv
// Shared types and default sizing for the SPI master transmitter.
package spi_pkg;

  localparam int SPI_DATA_W  = 8;
  localparam int SPI_CLK_DIV = 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEAD  = 3'd1,
    SHIFT = 3'd2,
    TRAIL = 3'd3,
    HOLD  = 3'd4
  } spi_state_t;

endpackage

// File: rtl/spi_master_tx_if.sv
// Host-side request bus plus the SPI pins of the transmitter.
interface spi_master_tx_if
  import spi_pkg::*;
#(
  parameter int DATA_W = SPI_DATA_W
);
  logic              newd;
  logic [DATA_W-1:0] din;
  logic              ready;
  logic              sclk;
  logic              cs;
  logic              mosi;
  logic              done;

  modport master (
    input  newd, din,
    output ready, sclk, cs, mosi, done
  );

  modport slave (
    output newd, din,
    input  ready, sclk, cs, mosi, done
  );
endinterface

// File: rtl/spi_sclk_gen.sv
// Half-period timer: ticks at the end of every CLK_DIV-cycle half and toggles sclk when allowed.
module spi_sclk_gen
  import spi_pkg::*;
#(
  parameter int CLK_DIV = SPI_CLK_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic sclk_en,
  output logic sclk,
  output logic half_tick,
  output logic rise_tick,
  output logic fall_tick
);
  localparam int CW = $clog2(CLK_DIV + 1);

  logic [CW-1:0] cnt;

  // half_tick also paces the sclk-low HOLD phase, where sclk_en is off.
  assign half_tick = en && (cnt == CW'(CLK_DIV - 1));
  assign rise_tick = half_tick && sclk_en && !sclk;
  assign fall_tick = half_tick && sclk_en && sclk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else if (!en) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else begin
      cnt  <= half_tick ? '0 : cnt + CW'(1);
      sclk <= sclk_en ? (half_tick ? ~sclk : sclk) : 1'b0;
    end
  end
endmodule

// File: rtl/spi_master_tx.sv
// SPI master transmitter: one arming period, DATA_W data periods MSB first, a trailing period, then a hold.
module spi_master_tx
  import spi_pkg::*;
#(
  parameter int DATA_W  = SPI_DATA_W,
  parameter int CLK_DIV = SPI_CLK_DIV
) (
  input logic           clk,
  input logic           rst_n,
  spi_master_tx_if.master bus
);
  localparam int BW = $clog2(DATA_W + 1);

  spi_state_t        state, state_nxt;
  logic [DATA_W-1:0] shreg, shreg_nxt;
  logic [BW-1:0]     bitcnt, bitcnt_nxt;
  logic              cs_q, cs_nxt;
  logic              mosi_q, mosi_nxt;
  logic              done_q, done_nxt;
  logic              gen_en, sclk_en, sclk_w;
  logic              half_tick, rise_tick, fall_tick;

  assign sclk_en = (state == LEAD) || (state == SHIFT) || (state == TRAIL);
  assign gen_en  = sclk_en || (state == HOLD);

  spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (gen_en),
    .sclk_en   (sclk_en),
    .sclk      (sclk_w),
    .half_tick (half_tick),
    .rise_tick (rise_tick),
    .fall_tick (fall_tick)
  );

  assign bus.sclk  = sclk_w;
  assign bus.cs    = cs_q;
  assign bus.mosi  = mosi_q;
  assign bus.done  = done_q;
  assign bus.ready = (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.newd) state_nxt = LEAD;
      LEAD:    if (fall_tick) state_nxt = SHIFT;
      SHIFT:   if (fall_tick && (bitcnt == BW'(DATA_W - 1))) state_nxt = TRAIL;
      TRAIL:   if (fall_tick) state_nxt = HOLD;
      HOLD:    if (half_tick) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // mosi only ever moves on a rise, so it is settled a full half-period before each fall.
  always_comb begin
    shreg_nxt  = shreg;
    bitcnt_nxt = bitcnt;
    cs_nxt     = cs_q;
    mosi_nxt   = mosi_q;
    done_nxt   = 1'b0;
    case (state)
      IDLE: if (bus.newd) begin
        shreg_nxt  = bus.din;
        bitcnt_nxt = '0;
        cs_nxt     = 1'b0;
      end
      SHIFT: begin
        if (rise_tick) begin
          mosi_nxt  = shreg[DATA_W-1];
          shreg_nxt = shreg << 1;
        end
        if (fall_tick) bitcnt_nxt = bitcnt + BW'(1);
      end
      TRAIL: if (rise_tick) mosi_nxt = 1'b0;
      HOLD: if (half_tick) begin
        cs_nxt   = 1'b1;
        done_nxt = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bitcnt <= '0;
      cs_q   <= 1'b1;
      mosi_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      bitcnt <= bitcnt_nxt;
      cs_q   <= cs_nxt;
      mosi_q <= mosi_nxt;
      done_q <= done_nxt;
    end
  end

  always_ff @(posedge clk) begin
    shreg <= shreg_nxt;
  end
endmodule
